comp_seq_ctrl: RTL and testbench

COMP_SEQ_CTRL -- requirements
Module: comp_seq_ctrl

---
 rtl/comp_seq_ctrl_pkg.sv | 20 ++
 rtl/comp_seq_ctrl_comp2.sv | 21 ++
 rtl/comp_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_comp_seq_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/comp_seq_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | comp_seq_pkg: shared state encoding and default operand width for    |
// | the sequential slice comparator.                                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package comp_seq_pkg;

  localparam int c_default_width = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/comp_seq_ctrl_comp2.sv
// +----------------------------------------------------------------------+
// | comp_2: 2-bit cascadable magnitude comparator slice.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module comp_2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       eq0,
  input  logic       gt0,
  output logic       eq1,
  output logic       gt1
);

  assign eq1 = eq0 & (a == b);
  assign gt1 = gt0 | (eq0 & (a > b));

endmodule

`default_nettype wire

// File: rtl/comp_seq_ctrl.sv
// +----------------------------------------------------------------------+
// | comp_seq_ctrl: unsigned A/B compare, one 2-bit slice per clock,      |
// | MSB slice first, optional early exit on the first unequal slice.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module comp_seq_ctrl
  import comp_seq_pkg::*;
#(
  parameter int WIDTH      = c_default_width,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int c_slices = WIDTH / 2;
  localparam int c_idx_w  = (c_slices > 1) ? $clog2(c_slices) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_slices - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [c_idx_w-1:0] r_idx;
  logic               r_eq_run;
  logic               r_gt_run;
  logic               r_busy;
  logic               r_done;
  logic               r_eq;
  logic               r_gt;
  logic               r_lt;

  logic [1:0]         w_sa;
  logic [1:0]         w_sb;
  logic               w_eq1;
  logic               w_gt1;
  logic               w_exit;

  always_comb begin
    w_sa = '0;
    w_sb = '0;
    for (int i = 0; i < c_slices; i++) begin
      if (r_idx == c_idx_w'(i)) begin
        w_sa = r_a[2*i +: 2];
        w_sb = r_b[2*i +: 2];
      end
    end
  end

  comp_2 u_comp_2 (
    .a   (w_sa),
    .b   (w_sb),
    .eq0 (r_eq_run),
    .gt0 (r_gt_run),
    .eq1 (w_eq1),
    .gt1 (w_gt1)
  );

  // Slice 0 always finishes; early exit also stops once the chain is decided.
  assign w_exit = (r_idx == '0) || ((EARLY_EXIT != 0) && !w_eq1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_eq_run <= 1'b0;
      r_gt_run <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_eq     <= 1'b0;
      r_gt     <= 1'b0;
      r_lt     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state  <= RUN;
            r_a      <= a;
            r_b      <= b;
            r_idx    <= c_last_idx;
            r_eq_run <= 1'b1;
            r_gt_run <= 1'b0;
            r_busy   <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_eq_run <= w_eq1;
          r_gt_run <= w_gt1;
          r_idx    <= r_idx - 1'b1;
          if (w_exit) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_eq    <= w_eq1;
            r_gt    <= w_gt1;
            r_lt    <= ~w_eq1 & ~w_gt1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign eq   = r_eq;
  assign gt   = r_gt;
  assign lt   = r_lt;

endmodule

`default_nettype wire

// File: tb/tb_comp_seq_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_comp_seq_ctrl: vector table, random pairs and corner sequences    |
// | against early-exit and full-run instances of comp_seq_ctrl.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_comp_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy1, done1, eq1, gt1, lt1;
  logic        busy0, done0, eq0, gt0, lt0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  comp_seq_ctrl #(.WIDTH(16), .EARLY_EXIT(1)) u_ee1 (
    .clock(clk), .reset(rst), .start(start), .a(a), .b(b),
    .busy(busy1), .done(done1), .eq(eq1), .gt(gt1), .lt(lt1)
  );

  comp_seq_ctrl #(.WIDTH(16), .EARLY_EXIT(0)) u_ee0 (
    .clock(clk), .reset(rst), .start(start), .a(a), .b(b),
    .busy(busy0), .done(done0), .eq(eq0), .gt(gt0), .lt(lt0)
  );

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [2:0]  res;   // {eq, gt, lt}
    int          lat1;
    int          lat0;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Expected result from plain unsigned arithmetic.
  function automatic logic [2:0] model_res(input logic [15:0] x, input logic [15:0] y);
    return {x == y, x > y, x < y};
  endfunction

  // Done edge count: the full run takes 8 slices; early exit stops at the
  // slice holding the most significant differing bit.
  function automatic int model_lat(input logic [15:0] x, input logic [15:0] y, input bit ee);
    logic [15:0] d;
    int h;
    d = x ^ y;
    if (!ee || d == 16'h0) return 8;
    h = 0;
    for (int k = 0; k < 16; k++) if (d[k]) h = k;
    return 8 - h / 2;
  endfunction

  // Invariants: done never with busy, never two cycles running.
  logic pd1 = 1'b0, pd0 = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      pd1 = 1'b0;
      pd0 = 1'b0;
    end else begin
      checks++;
      if ((busy1 && done1) || (busy0 && done0) || (pd1 && done1) || (pd0 && done0)) begin
        failures++;
        $display("FAIL invariant busy1=%0b done1=%0b busy0=%0b done0=%0b required no overlap/repeat",
                 busy1, done1, busy0, done0);
      end
      pd1 = done1;
      pd0 = done0;
    end
  end

  // Launch one compare; optionally release reset on the launching edge and
  // retry start while busy. Operands wiggle every cycle after capture.
  task automatic run_cmp(input logic [15:0] ta, input logic [15:0] tb, input int busy_start,
                         input bit release_rst,
                         output int l1, output int l0, output logic [2:0] r1, output logic [2:0] r0,
                         output int n1, output int n0);
    @(negedge clk);
    if (release_rst) rst = 1'b0;
    start = 1'b1; a = ta; b = tb;
    @(posedge clk); #1;
    start = 1'b0;
    l1 = -1; l0 = -1; n1 = 0; n0 = 0; r1 = 3'b000; r0 = 3'b000;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (done1) begin n1++; if (l1 < 0) begin l1 = n; r1 = {eq1, gt1, lt1}; end end
      if (done0) begin n0++; if (l0 < 0) begin l0 = n; r0 = {eq0, gt0, lt0}; end end
      if (n == busy_start) begin start = 1'b1; a = 16'hFFFF; b = ~b; end
      else begin start = 1'b0; a = ~a; b = 16'($urandom); end
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v, input int busy_start, input bit rel);
    int l1, l0, n1, n0;
    logic [2:0] r1, r0;
    run_cmp(v.va, v.vb, busy_start, rel, l1, l0, r1, r0, n1, n0);
    chk({tag, " res_ee1"}, int'(r1), int'(v.res));
    chk({tag, " res_ee0"}, int'(r0), int'(v.res));
    chk({tag, " lat_ee1"}, l1, v.lat1);
    chk({tag, " lat_ee0"}, l0, v.lat0);
    chk({tag, " pulses_ee1"}, n1, 1);
    chk({tag, " pulses_ee0"}, n0, 1);
  endtask

  vec_t tbl[7];

  initial begin
    int d1a, d1b, d0a, d0b;
    logic [2:0] res1, res0;
    vec_t v;

    tbl[0] = '{16'hA5A5, 16'hA5A5, 3'b100, 8, 8};
    tbl[1] = '{16'hC000, 16'h4000, 3'b010, 1, 8};
    tbl[2] = '{16'h0001, 16'h0002, 3'b001, 8, 8};
    tbl[3] = '{16'h0003, 16'h0003, 3'b100, 8, 8};
    tbl[4] = '{16'h8000, 16'h7FFF, 3'b010, 1, 8};
    tbl[5] = '{16'h0100, 16'h0200, 3'b001, 4, 8};
    tbl[6] = '{16'h1234, 16'h1235, 3'b001, 8, 8};

    rst = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", int'({busy1, busy0}), 0);
    chk("reset done", int'({done1, done0}), 0);
    chk("reset eq", int'({eq1, eq0}), 0);
    chk("reset gt", int'({gt1, gt0}), 0);
    chk("reset lt", int'({lt1, lt0}), 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 7; i++) check_vec($sformatf("vec%0d", i), tbl[i], 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      v.va = 16'($urandom);
      if ($urandom_range(0, 2) == 0) v.vb = v.va ^ (16'($urandom) >> $urandom_range(0, 15));
      else v.vb = 16'($urandom);
      v.res  = model_res(v.va, v.vb);
      v.lat1 = model_lat(v.va, v.vb, 1'b1);
      v.lat0 = model_lat(v.va, v.vb, 1'b0);
      check_vec($sformatf("rnd%0d", i), v, 0, 1'b0);
    end

    // Start retried at RUN cycle 3 with a=FFFF while operands toggle.
    v = '{16'h1234, 16'h1200, 3'b010, 6, 8};
    check_vec("busy_start", v, 2, 1'b0);

    // Back-to-back: start held through DONE with new operands.
    d1a = -1; d1b = -1; d0a = -1; d0b = -1; res1 = 3'b000; res0 = 3'b000;
    @(negedge clk); start = 1'b1; a = 16'h0005; b = 16'h0005;
    @(posedge clk); #1;
    a = 16'h0000; b = 16'hFFFF;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done1) begin if (d1a < 0) d1a = n; else begin d1b = n; res1 = {eq1, gt1, lt1}; end end
      if (done0) begin if (d0a < 0) d0a = n; else begin d0b = n; res0 = {eq0, gt0, lt0}; end end
      if (n == 9) begin
        chk("b2b busy_on_done_edge", int'({busy1, busy0}), 3);
        start = 1'b0;
      end
    end
    chk("b2b first_done_ee1", d1a, 8);
    chk("b2b first_done_ee0", d0a, 8);
    chk("b2b second_done_ee1", d1b, 10);
    chk("b2b second_done_ee0", d0b, 17);
    chk("b2b res_ee1", int'(res1), int'(3'b001));
    chk("b2b res_ee0", int'(res0), int'(3'b001));

    // Reset mid-RUN, asserted between edges.
    @(negedge clk); start = 1'b1; a = 16'h0003; b = 16'h0001;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #2; rst = 1'b1; #1;
    chk("midrst busy", int'({busy1, busy0}), 0);
    chk("midrst done", int'({done1, done0}), 0);
    chk("midrst eq", int'({eq1, eq0}), 0);
    chk("midrst gt", int'({gt1, gt0}), 0);
    chk("midrst lt", int'({lt1, lt0}), 0);
    repeat (2) @(posedge clk);
    v = '{16'h0003, 16'h0003, 3'b100, 8, 8};
    check_vec("after_rst", v, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
